// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared constants for the pattern scan controller: FSM encoding, detector
// pattern length and default sizing.
package pattern_scan_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_TAIL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int PATTERN_LEN     = 5;
  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_WORD_W  = 8;

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Requester-side bundle of the pattern scan controller: request/word inputs and
// the grant, result and handshake outputs.
interface pattern_scan_if
  import pattern_scan_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WORD_W  = DEFAULT_WORD_W
) ();

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int ID_W  = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*WORD_W-1:0] word_in;
  logic [NUM_REQ-1:0]        ack;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;
  logic                      done;
  logic [CNT_W-1:0]          match_cnt;

  modport master (
    output req, word_in,
    input  ack, busy, grant_id, done, match_cnt
  );

  modport slave (
    input  req, word_in,
    output ack, busy, grant_id, done, match_cnt
  );

endinterface

// File: rtl/pattern_scan_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping around to index 0.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               gnt_valid_o,
  output logic [ID_W-1:0]    gnt_id_o
);

  logic            found;
  logic [ID_W-1:0] pick;

  // First pass covers ptr..NUM_REQ-1, second pass supplies the wrapped candidates.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i] && (ID_W'(i) >= ptr_i)) begin
        found = 1'b1;
        pick  = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        found = 1'b1;
        pick  = ID_W'(i);
      end
    end
  end

  assign gnt_valid_o = found;
  assign gnt_id_o    = pick;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Time-shares one bit-serial "11010" detector among several requesters: grants
// round-robin, streams each word MSB-first and returns the match count.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter  int NUM_REQ = DEFAULT_NUM_REQ,
  parameter  int WORD_W  = DEFAULT_WORD_W,
  localparam int CNT_W   = $clog2(WORD_W + 1),
  localparam int ID_W    = $clog2(NUM_REQ),
  localparam int IDX_W   = $clog2(WORD_W)
) (
  input  logic           clk,
  input  logic           rst_n,
  pattern_scan_if.slave  bus,
  output logic           det_rst_o,
  output logic           det_in_o,
  input  logic           det_ind_i
);

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  match_q, match_d;

  logic              gntValid;
  logic [ID_W-1:0]   gntId;
  logic [ID_W-1:0]   ptrNext;
  logic [WORD_W-1:0] selWord;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
    .req_i      (bus.req),
    .ptr_i      (ptr_q),
    .gnt_valid_o(gntValid),
    .gnt_id_o   (gntId)
  );

  always_comb begin
    selWord = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gntId == ID_W'(i)) selWord = bus.word_in[i*WORD_W +: WORD_W];
    end
  end

  assign ptrNext = (gntId == ID_W'(NUM_REQ - 1)) ? '0 : gntId + ID_W'(1);

  // The latched word shifts left each SHIFT cycle so its MSB is always the bit
  // on det_in; det_ind reports the previous bit, hence the idx>=1 qualifier.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    case (state_q)
      ST_IDLE: begin
        if (gntValid) begin
          word_d  = selWord;
          gid_d   = gntId;
          ptr_d   = ptrNext;
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if ((idx_q != '0) && det_ind_i) cnt_d = satInc(cnt_q);
        word_d = word_q << 1;
        if (idx_q == IDX_W'(WORD_W - 1)) state_d = ST_TAIL;
        else                             idx_d   = idx_q + IDX_W'(1);
      end
      ST_TAIL: begin
        if (det_ind_i) cnt_d = satInc(cnt_q);
        match_d = cnt_d;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  // Detector is held in reset whenever it is not being fed a word.
  assign det_rst_o     = (state_q == ST_IDLE) || (state_q == ST_CLR) || (state_q == ST_DONE);
  assign det_in_o      = (state_q == ST_SHIFT) ? word_q[WORD_W-1] : 1'b0;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.ack       = (state_q == ST_DONE) ? (NUM_REQ'(1) << gid_q) : '0;
  assign bus.grant_id  = gid_q;
  assign bus.match_cnt = match_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: external "11010" detector, timeline model of the
// scan schedule, per-cycle compare, plus directed literal checks.
module tb_pattern_scan_ctrl;

  localparam int NUM_REQ = 4;
  localparam int WORD_W  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic detRst, detIn, detInd;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  pattern_scan_if #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W)) bus ();

  pattern_scan_ctrl #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .det_rst_o(detRst),
    .det_in_o (detIn),
    .det_ind_i(detInd)
  );

  // Overlapping "11010" detector with a registered history; ind is combinational.
  logic [4:0] hist  = 5'd0;
  int         nBits = 0;

  always @(posedge clk) begin
    if (detRst) begin
      hist  <= 5'd0;
      nBits <= 0;
    end else begin
      hist <= {hist[3:0], detIn};
      if (nBits < 5) nBits <= nBits + 1;
    end
  end

  assign detInd = (nBits >= 5) && (hist == 5'b11010);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int countMatches(input logic [WORD_W-1:0] w);
    int n;
    n = 0;
    for (int i = 0; i <= WORD_W - 5; i++)
      if (w[WORD_W-1-i -: 5] == 5'b11010) n++;
    return n;
  endfunction

  // Scan timeline: mK counts cycles since the granting edge (1=clear, 2..W+1
  // shifting, W+2 tail, W+3 done); mK=0 with mActive low means idle.
  bit                mActive = 1'b0;
  int                mK      = 0;
  int                mGid    = 0;
  int                mPtr    = 0;
  int                mExp    = 0;
  int                mMatch  = 0;
  int                mPick;
  logic [WORD_W-1:0] mWord   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mActive = 1'b0;
      mK      = 0;
      mGid    = 0;
      mPtr    = 0;
      mMatch  = 0;
    end else if (!mActive) begin
      if (bus.req != '0) begin
        mPick = -1;
        for (int o = 0; o < NUM_REQ; o++)
          if (mPick < 0 && bus.req[(mPtr + o) % NUM_REQ]) mPick = (mPtr + o) % NUM_REQ;
        mGid    = mPick;
        mPtr    = (mPick + 1) % NUM_REQ;
        mWord   = bus.word_in[mPick*WORD_W +: WORD_W];
        mExp    = countMatches(mWord);
        mActive = 1'b1;
        mK      = 1;
      end
    end else if (mK == WORD_W + 3) begin
      mActive = 1'b0;
      mK      = 0;
    end else begin
      mK++;
      if (mK == WORD_W + 3) mMatch = mExp;
    end
  end

  logic expDone;
  logic expDetIn;

  always @(negedge clk) begin
    expDone  = mActive && (mK == WORD_W + 3);
    expDetIn = (mActive && mK >= 2 && mK <= WORD_W + 1) ? mWord[WORD_W-1-(mK-2)] : 1'b0;
    checkOutput("busy", 32'(bus.busy), 32'(mActive));
    checkOutput("done", 32'(bus.done), 32'(expDone));
    checkOutput("ack", 32'(bus.ack), expDone ? (32'd1 << mGid) : 32'd0);
    if (mActive) checkOutput("grant_id", 32'(bus.grant_id), 32'(mGid));
    checkOutput("match_cnt", 32'(bus.match_cnt), 32'(mMatch));
    checkOutput("det_rst", 32'(detRst), 32'(!mActive || mK == 1 || mK == WORD_W + 3));
    checkOutput("det_in", 32'(detIn), 32'(expDetIn));
  end

  // Serve one word; optionally drop req or rewrite the word at given cycles after grant.
  task automatic applyStimulus(input int id, input logic [WORD_W-1:0] w, input int expCnt,
                               input int dropAt, input int changeAt,
                               input logic [WORD_W-1:0] lateWord, input string tag);
    bit found;
    found = 1'b0;
    bus.word_in[id*WORD_W +: WORD_W] = w;
    bus.req[id] = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == dropAt) bus.req[id] = 1'b0;
      if (cyc == changeAt) bus.word_in[id*WORD_W +: WORD_W] = lateWord;
      if (bus.done) begin
        found = 1'b1;
        checkOutput({tag, "_latency"}, 32'(cyc), 32'd11);
        checkOutput({tag, "_ack"}, 32'(bus.ack), 32'd1 << id);
        checkOutput({tag, "_cnt"}, 32'(bus.match_cnt), 32'(expCnt));
        break;
      end
    end
    bus.req[id] = 1'b0;
    if (!found) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  int  rrIds[3]  = '{0, 1, 3};
  int  rrCnts[3] = '{1, 0, 1};
  int  nDone;
  int  lastCyc;

  initial begin
    bus.req     = '0;
    bus.word_in = '0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_det_rst", 32'(detRst), 32'd1);
    checkOutput("rst_det_in", 32'(detIn), 32'd0);
    checkOutput("rst_match", 32'(bus.match_cnt), 32'd0);
    checkOutput("rst_grant", 32'(bus.grant_id), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(0, 8'b11010000, 1, 0, 0, '0, "single");
    applyStimulus(0, 8'b11011010, 1, 0, 0, '0, "lastbit");
    applyStimulus(1, 8'hFF,       0, 0, 0, '0, "nomatch");
    applyStimulus(2, 8'b11010110, 1, 3, 0, '0, "earlydrop");

    // Reset during the fourth SHIFT cycle of a scan for requester 3.
    bus.word_in[3*WORD_W +: WORD_W] = 8'b11010110;
    bus.req[3] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("prerst_busy", 32'(bus.busy), 32'd1);
    checkOutput("prerst_grant", 32'(bus.grant_id), 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_done", 32'(bus.done), 32'd0);
    checkOutput("midrst_ack", 32'(bus.ack), 32'd0);
    checkOutput("midrst_grant", 32'(bus.grant_id), 32'd0);
    checkOutput("midrst_match", 32'(bus.match_cnt), 32'd0);
    checkOutput("midrst_det_rst", 32'(detRst), 32'd1);
    checkOutput("midrst_det_in", 32'(detIn), 32'd0);
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin from pointer 0 with three requesters pending together.
    bus.word_in = {8'b11010110, 8'h55, 8'h00, 8'h1A};
    bus.req     = 4'b1011;
    nDone   = 0;
    lastCyc = 0;
    for (int cyc = 1; cyc <= 60 && nDone < 3; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        checkOutput("rr_ack", 32'(bus.ack), 32'd1 << rrIds[nDone]);
        checkOutput("rr_cnt", 32'(bus.match_cnt), 32'(rrCnts[nDone]));
        checkOutput("rr_spacing", 32'(cyc - lastCyc), (nDone == 0) ? 32'd11 : 32'd12);
        lastCyc = cyc;
        bus.req = bus.req & ~bus.ack;
        nDone++;
      end
    end
    if (nDone != 3) checkOutput("rr_timeout", 32'(nDone), 32'd3);
    bus.req = '0;
    @(posedge clk);
    #1;

    applyStimulus(2, 8'hFF, 0, 0, 2, 8'b11010000, "latched");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
